cache_2way_ctrl: RTL
====================

# cache_2way_ctrl

Responder side of the cache request interface driven by the board front end. It receives address, write-enable and write data, and returns read data plus hit, miss and per-way dirty status. It implements a 4-set, 2-way set-associative, write-back, write-allocate cache with 1-byte lines and LRU replacement. A private 32-byte backing store with configurable access latency sits behind it.

## Interface
- `MEM_LAT`, default 2: backing-store access latency in cycles, legal range 1..15.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  1  request strobe; sampled only in IDLE.
- `address`  in  5  byte address; index = `address[1:0]`, tag = `address[4:2]`.
- `wren`  in  1  1 = write `data`, 0 = read.
- `data`  in  8  write data.
- `q`  out  8  read data (write requests return the written byte).
- `hit`  out  1  last completed request hit.
- `miss`  out  1  last completed request missed.
- `dirty1`  out  1  dirty bit of way 0 in the last accessed set.
- `dirty2`  out  1  dirty bit of way 1 in the last accessed set.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a request completes.

## Operation
- Per set: 2 ways × {valid, dirty, tag[2:0], byte[7:0]}, plus 1 LRU bit that names the least-recently-used way.
- Backing store `mem[0..31]` resets to `mem[i] = i`.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL.
- IDLE: if `req`=1, latch `address`, `wren` and `data`, then go to LOOKUP. `req` is ignored in every other state.
- LOOKUP on a hit (valid and tag match in either way):
  - read: `q` = line byte.
  - write: store the byte, set its dirty bit, `q` = `data`.
  - Set LRU to the other way, set `hit`=1 / `miss`=0, pulse `done`, go to IDLE.
- LOOKUP on a miss, victim selection:
  - The first invalid way is chosen, way 0 preferred.
  - If both ways are valid, the LRU way is chosen.
  - Victim valid and dirty: go to WRITEBACK. Otherwise go to FILL.
- WRITEBACK: hold `MEM_LAT` cycles, then write the victim byte to `mem[{victim_tag, index}]`, clear its dirty bit, go to FILL.
- FILL: hold `MEM_LAT` cycles, then load `mem[address]` into the victim and set valid and tag.
  - Write requests then overwrite the byte and set dirty.
  - Set LRU to the other way, update `q`, set `hit`=0 / `miss`=1, pulse `done`, go to IDLE.
- On every completion, `dirty1`/`dirty2` take the post-operation dirty bits of the accessed set.
- `q`, `hit`, `miss`, `dirty1` and `dirty2` hold between completions.
- The latency counter is 4 bits and reloads on entry to WRITEBACK and FILL.

## Timing
- Reset values: `q`=0, `hit`=0, `miss`=0, `dirty1`=0, `dirty2`=0, `busy`=0, `done`=0, state=IDLE, all valid/dirty/LRU bits=0, backing store reinitialised.
- Latency is counted from the `req`-sampling edge to the edge that asserts `done`:
  - hit: 2 cycles.
  - clean miss: 2+`MEM_LAT` cycles.
  - dirty miss: 2+2·`MEM_LAT` cycles.
- `done` is high for exactly one cycle. `busy` falls on the same edge that raises `done`.
- A `req` held high through `done` is accepted in the following IDLE cycle. There is no back-to-back acceptance on the `done` edge.
- Reset mid-operation aborts the operation with no partial writeback. Reset wins over any simultaneous edge event.
- A refill of the same address as the victim cannot occur, because the tags differ by construction.

## Configuration
- `CACHE_WRITE_THROUGH_EN` defined:
  - Every write also updates `mem` in the completing cycle.
  - Dirty bits are never set, so `dirty1`/`dirty2` stay 0.
  - WRITEBACK is unreachable and is compiled out.
- Not defined: write-back behaviour exactly as described above.

## Test plan
- Reset, then read `address`=5'h05:
  - miss=1, hit=0, `q`=8'h05, `done` 4 cycles after `req` (`MEM_LAT`=2).
  - Repeat the read: hit=1, `q`=8'h05, latency 2.
- Write 8'hAA to 5'h01, then read 5'h01: first access miss, `dirty1`=1, `q`=8'hAA; second access hit, `q`=8'hAA.
- Fill set 1 with writes to 5'h01 and 5'h05, then read 5'h09:
  - victim is way 0 (LRU) and dirty, latency 6 cycles, miss=1, `q`=8'h09.
  - Subsequent read of 5'h01: miss, `q`=8'hAA (written-back value).
- Pulse `req` while `busy`=1: the request is ignored, and exactly one `done` is produced per accepted request.
- Assert `reset` during FILL: all outputs 0 on the same cycle, then a read of 5'h01 misses and returns 8'h01.
- With `CACHE_WRITE_THROUGH_EN`: write 8'h3C to 5'h02, `dirty1`=`dirty2`=0, then evict via 5'h06 and 5'h0A and read 5'h02: `q`=8'h3C.

Source files
------------

// File: rtl/cache_2way_ctrl.sv
// 4-set, 2-way set-associative cache controller with 1-byte lines, LRU replacement and a private 32-byte backing store.
// Default build is write-back/write-allocate; defining CACHE_WRITE_THROUGH_EN makes writes update the store directly and removes WRITEBACK.
module cache_2way_ctrl #(
    parameter int MEM_LAT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic [4:0] address,
    input  logic       wren,
    input  logic [7:0] data,
    output logic [7:0] q,
    output logic       hit,
    output logic       miss,
    output logic       dirty1,
    output logic       dirty2,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LOOKUP    = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_FILL      = 2'd3;
    localparam logic [3:0] LAT_LOAD    = 4'(MEM_LAT);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [4:0] addr_r;
    logic       wren_r;
    logic [7:0] data_r;
    logic       cmp_valid;
    logic       hit_r;
    logic       way_r;
`ifndef CACHE_WRITE_THROUGH_EN
    logic       wb_r;
`endif

    logic [1:0] valid [4];
    logic [1:0] dirty [4];
    logic [2:0] tag   [4][2];
    logic [7:0] line  [4][2];
    logic [3:0] lru;
    logic [7:0] mem   [32];

    logic [1:0] idx;
    logic [2:0] tg;
    logic       hit0;
    logic       hit1;
    logic       victim;
    logic       new_dirty;
    logic [1:0] dirty_post;
    logic [7:0] fill_byte;

    assign idx  = addr_r[1:0];
    assign tg   = addr_r[4:2];
    assign busy = (state != S_IDLE);

    always_comb begin
        hit0 = valid[idx][0] && (tag[idx][0] == tg);
        hit1 = valid[idx][1] && (tag[idx][1] == tg);
        if (!valid[idx][0]) begin
            victim = 1'b0;
        end else if (!valid[idx][1]) begin
            victim = 1'b1;
        end else begin
            victim = lru[idx];
        end
`ifdef CACHE_WRITE_THROUGH_EN
        new_dirty = 1'b0;
`else
        // A hit read keeps the old dirty bit; a fill starts clean unless it is a write.
        new_dirty = wren_r | (hit_r & dirty[idx][way_r]);
`endif
        dirty_post         = dirty[idx];
        dirty_post[way_r]  = new_dirty;
        fill_byte          = wren_r ? data_r : mem[addr_r];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_r    <= 5'd0;
            wren_r    <= 1'b0;
            data_r    <= 8'd0;
            cmp_valid <= 1'b0;
            hit_r     <= 1'b0;
            way_r     <= 1'b0;
`ifndef CACHE_WRITE_THROUGH_EN
            wb_r      <= 1'b0;
`endif
            q         <= 8'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            dirty1    <= 1'b0;
            dirty2    <= 1'b0;
            done      <= 1'b0;
            lru       <= 4'd0;
            for (int s = 0; s < 4; s++) begin
                valid[s] <= 2'b00;
                dirty[s] <= 2'b00;
                for (int w = 0; w < 2; w++) begin
                    tag[s][w]  <= 3'd0;
                    line[s][w] <= 8'd0;
                end
            end
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 8'(i);
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_r    <= address;
                        wren_r    <= wren;
                        data_r    <= data;
                        cmp_valid <= 1'b0;
                        state     <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    // First cycle registers the tag compare and victim choice; second cycle acts on it.
                    if (!cmp_valid) begin
                        cmp_valid <= 1'b1;
                        hit_r     <= hit0 | hit1;
                        way_r     <= hit0 ? 1'b0 : (hit1 ? 1'b1 : victim);
`ifndef CACHE_WRITE_THROUGH_EN
                        wb_r      <= valid[idx][victim] & dirty[idx][victim];
`endif
                    end else begin
                        cmp_valid <= 1'b0;
                        if (hit_r) begin
                            if (wren_r) begin
                                line[idx][way_r] <= data_r;
                                q                <= data_r;
`ifdef CACHE_WRITE_THROUGH_EN
                                mem[addr_r]      <= data_r;
`endif
                            end else begin
                                q <= line[idx][way_r];
                            end
                            dirty[idx][way_r] <= new_dirty;
                            lru[idx]          <= ~way_r;
                            hit               <= 1'b1;
                            miss              <= 1'b0;
                            dirty1            <= dirty_post[0];
                            dirty2            <= dirty_post[1];
                            done              <= 1'b1;
                            state             <= S_IDLE;
`ifndef CACHE_WRITE_THROUGH_EN
                        end else if (wb_r) begin
                            cnt   <= LAT_LOAD;
                            state <= S_WRITEBACK;
`endif
                        end else begin
                            cnt   <= LAT_LOAD;
                            state <= S_FILL;
                        end
                    end
                end

`ifndef CACHE_WRITE_THROUGH_EN
                S_WRITEBACK: begin
                    if (cnt == 4'd1) begin
                        mem[{tag[idx][way_r], idx}] <= line[idx][way_r];
                        dirty[idx][way_r]           <= 1'b0;
                        cnt                         <= LAT_LOAD;
                        state                       <= S_FILL;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`endif

                S_FILL: begin
                    if (cnt == 4'd1) begin
                        valid[idx][way_r] <= 1'b1;
                        tag[idx][way_r]   <= tg;
                        line[idx][way_r]  <= fill_byte;
                        dirty[idx][way_r] <= new_dirty;
`ifdef CACHE_WRITE_THROUGH_EN
                        if (wren_r) begin
                            mem[addr_r] <= data_r;
                        end
`endif
                        lru[idx] <= ~way_r;
                        q        <= fill_byte;
                        hit      <= 1'b0;
                        miss     <= 1'b1;
                        dirty1   <= dirty_post[0];
                        dirty2   <= dirty_post[1];
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
